// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Multi-cycle unsigned shift-add multiplier for the ALU datapath. One W+1 bit
// adder is reused for W iterations instead of building an array multiplier.
// The full 2W-bit product is registered on the completing edge and held until
// the next completion, so the downstream pipeline register never sees a
// partial sum.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       request a multiply (accepted in IDLE or DONE)
//   a           multiplicand, unsigned, sampled on the accepting edge
//   b           multiplier, unsigned, sampled on the accepting edge
//   busy        high while an operation is in progress
//   done        one-cycle pulse, product valid
//   product_lo  low W bits of a*b
//   product_hi  high W bits of a*b
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product_lo,
    output logic [W-1:0] product_hi
);

    // Iteration counter width is derived from W and not meant to be overridden.
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    // Accumulator layout: {carry, upper W bits, lower W bits}. The lower half
    // starts as the multiplier and is consumed one bit per iteration while the
    // product grows in from the top.
    logic [2*W:0]   acc;
    logic [W-1:0]   multiplicand;
    logic [CW-1:0]  counter;

    logic [W:0]     partial;
    logic [2*W:0]   acc_step;
    logic           accept;
    logic           last_iter;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == RUN) && (counter == CW'(W - 1));

    // One shift-add iteration. The add is W+1 bits wide so the carry out of
    // the upper half lands in bit 2W before the shift pulls it back down.
    always_comb begin
        partial = acc[2*W:W];
        if (acc[0]) begin
            partial = acc[2*W:W] + {1'b0, multiplicand};
        end
        acc_step = {1'b0, partial, acc[W-1:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs. busy and done decode disjoint states, so
    // they can never be high together.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operands are captured only on an accepting edge, so start
    // pulses while running and later operand changes have no effect. The
    // product registers load only on the edge that finishes iteration W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            multiplicand <= '0;
            counter      <= '0;
            product_lo   <= '0;
            product_hi   <= '0;
        end else if (accept) begin
            multiplicand <= a;
            acc          <= {{(W + 1){1'b0}}, b};
            counter      <= '0;
        end else if (state == RUN) begin
            acc     <= acc_step;
            counter <= counter + CW'(1);
            if (last_iter) begin
                product_hi <= acc_step[2*W-1:W];
                product_lo <= acc_step[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Self-checking bench for seq_multiplier (W=32). A behavioural model tracks
// the accepted operation as a plain a*b product plus a cycle countdown, and a
// compare process checks busy, done and both product halves every cycle.
// Directed scenarios pin the model with hand-computed literals; a random
// phase follows.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] product_lo;
    logic [W-1:0] product_hi;

    int compared = 0;
    int mismatched = 0;
    bit checkEn = 0;

    // Behavioural model state.
    int           remaining;
    bit           expDone;
    logic [63:0]  expProd;
    logic [63:0]  pendProd;

    seq_multiplier #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared comparison: counts every check and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Model: an accepted request yields a*b exactly W edges later; while an
    // operation is outstanding any start is ignored. Reset drops everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining = 0;
            expDone   = 1'b0;
            expProd   = '0;
            pendProd  = '0;
        end else begin
            expDone = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    expDone = 1'b1;
                    expProd = pendProd;
                end
            end else if (start) begin
                pendProd  = {32'b0, a} * {32'b0, b};
                remaining = W;
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", {63'b0, busy}, {63'b0, (remaining > 0)});
            checkOutput("done", {63'b0, done}, {63'b0, expDone});
            checkOutput("product_lo", {32'b0, product_lo}, {32'b0, expProd[31:0]});
            checkOutput("product_hi", {32'b0, product_hi}, {32'b0, expProd[63:32]});
        end
    end

    // Present one start pulse with the given operands, then scramble the
    // operands. Returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // At the done cycle: check the pulse and the literal product, and pin the
    // model to the same literal.
    task automatic checkResult(input string name, input logic [63:0] lit);
        checkOutput({name, "_done"}, {63'b0, done}, 64'd1);
        checkOutput({name, "_busy"}, {63'b0, busy}, 64'd0);
        checkOutput({name, "_product"}, {product_hi, product_lo}, lit);
        checkOutput({name, "_model"}, expProd, lit);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        checkEn = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", {63'b0, busy}, 64'd0);
        checkOutput("rst_done", {63'b0, done}, 64'd0);
        checkOutput("rst_product", {product_hi, product_lo}, 64'd0);
        rst = 1'b0;

        // 3*5: done arrives W cycles after acceptance.
        applyStimulus(32'd3, 32'd5);
        checkOutput("small_busy_first", {63'b0, busy}, 64'd1);
        repeat (W) @(negedge clk);
        checkResult("small", 64'h0000_0000_0000_000F);

        // Largest operands exercise the carry out of the adder.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (W) @(negedge clk);
        checkResult("max", 64'hFFFF_FFFE_0000_0001);

        // Zero operands still take the full latency.
        applyStimulus(32'h1234_5678, 32'h0);
        repeat (W) @(negedge clk);
        checkResult("zero_b", 64'h0);
        applyStimulus(32'h0, 32'h9ABC_DEF0);
        repeat (W) @(negedge clk);
        checkResult("zero_a", 64'h0);

        // Start while busy is ignored.
        applyStimulus(32'd7, 32'd6);
        repeat (9) @(negedge clk);
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (W - 10) @(negedge clk);
        checkResult("ignored", 64'h2A);
        @(negedge clk);
        checkOutput("ignored_single_pulse", {63'b0, done}, 64'd0);

        // Back-to-back: start held high through the done cycle.
        @(negedge clk);
        start = 1'b1;
        a     = 32'h0001_0000;
        b     = 32'h0001_0000;
        @(negedge clk);
        a     = 32'd9;
        b     = 32'd9;
        repeat (W) @(negedge clk);
        checkResult("b2b_first", 64'h0000_0001_0000_0000);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy_again", {63'b0, busy}, 64'd1);
        repeat (W) @(negedge clk);
        checkResult("b2b_second", 64'h51);

        // Asynchronous reset mid-operation.
        applyStimulus($urandom, $urandom);
        repeat (14) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", {63'b0, busy}, 64'd0);
        checkOutput("async_rst_done", {63'b0, done}, 64'd0);
        checkOutput("async_rst_product", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'd4, 32'd4);
        repeat (W) @(negedge clk);
        checkResult("after_rst", 64'h10);

        // Random phase: random starts (including while busy and in the done
        // cycle), random operands with corner values mixed in.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       a = '0;
                1:       a = '1;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = '1;
                default: b = $urandom;
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
